// File: rtl/mem_load_ctrl.sv
// Load side of the MEM stage: issues BRAM reads for aligned loads, waits the
// read latency, then extracts and extends the addressed byte/halfword.

package mem_load_pkg;

  typedef enum logic [3:0] {
    MEMOP_NOP = 4'd0,
    MEMOP_LW  = 4'd1,
    MEMOP_LH  = 4'd2,
    MEMOP_LHU = 4'd3,
    MEMOP_LB  = 4'd4,
    MEMOP_LBU = 4'd5,
    MEMOP_SW  = 4'd6,
    MEMOP_SH  = 4'd7,
    MEMOP_SB  = 4'd8
  } mem_op_e;

endpackage

module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_en,
  input  mem_op_e     ex_mem_op,
  input  logic [31:0] ex_out,
  input  logic        flush,
  output logic        req_ready,
  output logic [31:0] addr,
  output logic        rea,
  input  logic [31:0] rd_data,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        miss_align,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_op_e            op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               miss_align_q, miss_align_d;

  logic is_load;
  logic misaligned;
  logic accept;

  // Little-endian lane select, mirroring the store path's byte-lane shift.
  function automatic logic [31:0] extract(input mem_op_e     op,
                                          input logic [1:0]  off,
                                          input logic [31:0] data);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = off[1] ? data[31:16] : data[15:0];
    byte_v = data[{off, 3'b000} +: 8];
    case (op)
      MEMOP_LH:  extract = {{16{half[15]}}, half};
      MEMOP_LHU: extract = {16'h0000, half};
      MEMOP_LB:  extract = {{24{byte_v[7]}}, byte_v};
      MEMOP_LBU: extract = {24'h000000, byte_v};
      default:   extract = data;
    endcase
  endfunction

  assign is_load    = ex_mem_op inside {MEMOP_LW, MEMOP_LH, MEMOP_LHU, MEMOP_LB, MEMOP_LBU};
  assign misaligned = ((ex_mem_op == MEMOP_LW) && (ex_out[1:0] != 2'b00)) ||
                      (((ex_mem_op == MEMOP_LH) || (ex_mem_op == MEMOP_LHU)) && ex_out[0]);

  assign req_ready  = (state_q != S_WAIT);
  assign busy       = ~req_ready;
  assign accept     = ex_en && req_ready && !flush;
  assign rea        = accept && is_load && !misaligned;
  assign addr       = ex_out;

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign miss_align = miss_align_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    miss_align_d = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (is_load && !misaligned) begin
              op_d    = ex_mem_op;
              off_d   = ex_out[1:0];
              cnt_d   = CNT_W'(RD_LATENCY - 1);
              state_d = S_WAIT;
            end else if (is_load) begin
              out_d        = 32'h0000_0000;
              out_valid_d  = 1'b1;
              miss_align_d = 1'b1;
              state_d      = S_RESP;
            end else begin
              out_d       = ex_out;
              out_valid_d = 1'b1;
              state_d     = S_RESP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          // cnt_q reaching zero marks the cycle in which rd_data is valid.
          if (cnt_q == '0) begin
            out_d       = extract(op_q, off_q, rd_data);
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= MEMOP_NOP;
      off_q        <= 2'b00;
      out_q        <= 32'h0000_0000;
      out_valid_q  <= 1'b0;
      miss_align_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      off_q        <= off_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      miss_align_q <= miss_align_d;
    end
  end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl: one instance at RD_LATENCY=1, one at
// RD_LATENCY=3, driven and sampled on the falling clock edge.

module tb_mem_load_ctrl;
  import mem_load_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  mem_op_e     ex_mem_op;
  logic [31:0] ex_out;

  logic        ex_en1, flush1, req_ready1, rea1, out_valid1, miss_align1, busy1;
  logic [31:0] rd_data1, addr1, out1;
  logic        ex_en3, flush3, req_ready3, rea3, out_valid3, miss_align3, busy3;
  logic [31:0] rd_data3, addr3, out3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_load_ctrl #(.RD_LATENCY(1), .CNT_W(2)) u_lat1 (
    .clk(clk), .reset(reset), .ex_en(ex_en1), .ex_mem_op(ex_mem_op), .ex_out(ex_out),
    .flush(flush1), .req_ready(req_ready1), .addr(addr1), .rea(rea1), .rd_data(rd_data1),
    .out(out1), .out_valid(out_valid1), .miss_align(miss_align1), .busy(busy1)
  );

  mem_load_ctrl #(.RD_LATENCY(3), .CNT_W(2)) u_lat3 (
    .clk(clk), .reset(reset), .ex_en(ex_en3), .ex_mem_op(ex_mem_op), .ex_out(ex_out),
    .flush(flush3), .req_ready(req_ready3), .addr(addr3), .rea(rea3), .rd_data(rd_data3),
    .out(out3), .out_valid(out_valid3), .miss_align(miss_align3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Aligned load on the latency-1 instance: accept at T, data at T+1, result at T+2.
  task automatic load1(input string tag, input mem_op_e op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk); ex_en1 = 1'b1; ex_mem_op = op; ex_out = a; rd_data1 = 32'hDEAD_BEEF; #1;
    check({tag, " rea@T"}, 32'(rea1), 32'd1);
    check({tag, " addr@T"}, addr1, a);
    @(negedge clk); ex_en1 = 1'b0; rd_data1 = d; #1;
    check({tag, " busy@T+1"}, 32'(busy1), 32'd1);
    check({tag, " out_valid@T+1"}, 32'(out_valid1), 32'd0);
    @(negedge clk); rd_data1 = 32'hDEAD_BEEF; #1;
    check({tag, " out_valid@T+2"}, 32'(out_valid1), 32'd1);
    check({tag, " out@T+2"}, out1, exp);
    check({tag, " miss_align@T+2"}, 32'(miss_align1), 32'd0);
    check({tag, " busy@T+2"}, 32'(busy1), 32'd0);
  endtask

  task automatic misal1(input string tag, input mem_op_e op, input logic [31:0] a);
    @(negedge clk); ex_en1 = 1'b1; ex_mem_op = op; ex_out = a; #1;
    check({tag, " rea@T"}, 32'(rea1), 32'd0);
    @(negedge clk); ex_en1 = 1'b0; #1;
    check({tag, " rea@T+1"}, 32'(rea1), 32'd0);
    check({tag, " out_valid@T+1"}, 32'(out_valid1), 32'd1);
    check({tag, " miss_align@T+1"}, 32'(miss_align1), 32'd1);
    check({tag, " out@T+1"}, out1, 32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; ex_mem_op = MEMOP_NOP; ex_out = 32'h0;
    ex_en1 = 1'b0; flush1 = 1'b0; rd_data1 = 32'h0;
    ex_en3 = 1'b0; flush3 = 1'b0; rd_data3 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset out1", out1, 32'h0);
    check("reset out_valid1", 32'(out_valid1), 32'd0);
    check("reset miss_align1", 32'(miss_align1), 32'd0);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset out_valid3", 32'(out_valid3), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Byte / halfword / word extraction at latency 1.
    load1("LB 0x103", MEMOP_LB, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    load1("LBU 0x103", MEMOP_LBU, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
    load1("LH 0x202", MEMOP_LH, 32'h0000_0202, 32'h9ABC_5678, 32'hFFFF_9ABC);
    load1("LHU 0x202", MEMOP_LHU, 32'h0000_0202, 32'h9ABC_5678, 32'h0000_9ABC);
    load1("LW 0x200", MEMOP_LW, 32'h0000_0200, 32'h9ABC_5678, 32'h9ABC_5678);
    load1("LBU 0x101", MEMOP_LBU, 32'h0000_0101, 32'h80FF_1234, 32'h0000_0012);

    // Misaligned loads never reach memory and report out=0 with miss_align.
    misal1("mis LW 0x201", MEMOP_LW, 32'h0000_0201);
    misal1("mis LH 0x203", MEMOP_LH, 32'h0000_0203);
    @(negedge clk); #1;
    check("mis tail out_valid", 32'(out_valid1), 32'd0);
    check("mis tail miss_align", 32'(miss_align1), 32'd0);

    // Back-to-back: LW, then LB accepted in the RESP cycle, then a store pass-through.
    @(negedge clk); ex_en1 = 1'b1; ex_mem_op = MEMOP_LW; ex_out = 32'h0000_0200; #1;
    check("b2b LW rea", 32'(rea1), 32'd1);
    @(negedge clk); ex_mem_op = MEMOP_LB; ex_out = 32'h0000_0103; rd_data1 = 32'h1122_3344; #1;
    check("b2b WAIT busy", 32'(busy1), 32'd1);
    check("b2b WAIT rea ignored", 32'(rea1), 32'd0);
    @(negedge clk); rd_data1 = 32'hDEAD_BEEF; #1;
    check("b2b LW out_valid", 32'(out_valid1), 32'd1);
    check("b2b LW out", out1, 32'h1122_3344);
    check("b2b LB rea in RESP", 32'(rea1), 32'd1);
    check("b2b RESP busy", 32'(busy1), 32'd0);
    @(negedge clk); ex_mem_op = MEMOP_SW; ex_out = 32'h1234_5678; rd_data1 = 32'h80FF_1234; #1;
    check("b2b LB WAIT busy", 32'(busy1), 32'd1);
    check("b2b LB WAIT out_valid", 32'(out_valid1), 32'd0);
    @(negedge clk); rd_data1 = 32'hDEAD_BEEF; #1;
    check("b2b LB out_valid", 32'(out_valid1), 32'd1);
    check("b2b LB out", out1, 32'hFFFF_FF80);
    check("b2b SW rea", 32'(rea1), 32'd0);
    @(negedge clk); ex_en1 = 1'b0; #1;
    check("b2b SW out_valid", 32'(out_valid1), 32'd1);
    check("b2b SW out", out1, 32'h1234_5678);
    check("b2b SW miss_align", 32'(miss_align1), 32'd0);
    check("b2b SW busy", 32'(busy1), 32'd0);
    @(negedge clk); #1;
    check("b2b idle out_valid", 32'(out_valid1), 32'd0);
    check("b2b out hold", out1, 32'h1234_5678);

    // Flush blocks an accept in its own cycle.
    @(negedge clk); ex_en1 = 1'b1; flush1 = 1'b1; ex_mem_op = MEMOP_LW; ex_out = 32'h0000_0300; #1;
    check("flush blocks rea", 32'(rea1), 32'd0);
    @(negedge clk); ex_en1 = 1'b0; flush1 = 1'b0; #1;
    check("flush blocks out_valid", 32'(out_valid1), 32'd0);
    check("flush blocks busy", 32'(busy1), 32'd0);

    // Latency 3: only the T+3 data word is captured.
    @(negedge clk); ex_en3 = 1'b1; ex_mem_op = MEMOP_LB; ex_out = 32'h0000_0101; rd_data3 = 32'h0; #1;
    check("lat3 rea@T", 32'(rea3), 32'd1);
    @(negedge clk); ex_en3 = 1'b0; rd_data3 = 32'h1111_1111; #1;
    check("lat3 busy@T+1", 32'(busy3), 32'd1);
    @(negedge clk); rd_data3 = 32'h2222_2222; #1;
    check("lat3 busy@T+2", 32'(busy3), 32'd1);
    @(negedge clk); rd_data3 = 32'hAABB_CCDD; #1;
    check("lat3 busy@T+3", 32'(busy3), 32'd1);
    check("lat3 out_valid@T+3", 32'(out_valid3), 32'd0);
    @(negedge clk); rd_data3 = 32'h3333_3333; #1;
    check("lat3 out_valid@T+4", 32'(out_valid3), 32'd1);
    check("lat3 out@T+4", out3, 32'hFFFF_FFCC);
    @(negedge clk); #1;
    check("lat3 out_valid@T+5", 32'(out_valid3), 32'd0);

    // Latency 3 with a flush at T+2.
    @(negedge clk); ex_en3 = 1'b1; ex_mem_op = MEMOP_LW; ex_out = 32'h0000_0200; #1;
    check("lat3 flush rea@T", 32'(rea3), 32'd1);
    @(negedge clk); ex_en3 = 1'b0; #1;
    check("lat3 flush busy@T+1", 32'(busy3), 32'd1);
    @(negedge clk); flush3 = 1'b1; #1;
    check("lat3 flush busy@T+2", 32'(busy3), 32'd1);
    @(negedge clk); flush3 = 1'b0; rd_data3 = 32'h5555_5555; #1;
    check("lat3 flush idle@T+3", 32'(busy3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("lat3 flush no out_valid", 32'(out_valid3), 32'd0);
    end
    check("lat3 flush out hold", out3, 32'hFFFF_FFCC);

    // Asynchronous reset while waiting on the BRAM.
    @(negedge clk); ex_en3 = 1'b1; ex_mem_op = MEMOP_LHU; ex_out = 32'h0000_0102; #1;
    check("rst rea@T", 32'(rea3), 32'd1);
    @(negedge clk); ex_en3 = 1'b0; #1;
    check("rst busy before", 32'(busy3), 32'd1);
    reset = 1'b1; #1;
    check("rst async out3", out3, 32'h0);
    check("rst async out_valid3", 32'(out_valid3), 32'd0);
    check("rst async busy3", 32'(busy3), 32'd0);
    check("rst async out1", out1, 32'h0);
    @(negedge clk); reset = 1'b0; rd_data3 = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("rst no stray out_valid", 32'(out_valid3), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
- Load-side counterpart of the store path in the MEM stage.
- Accepts load requests from EX and issues a read to the synchronous data BRAM.
- Waits the BRAM read latency, then extracts the addressed byte or halfword and sign- or zero-extends it to the word result.
- Non-load ops pass the EX result through. Misaligned loads are flagged and never reach memory.

Parameters:
- RD_LATENCY, 1, BRAM read latency in cycles (1..3): rd_data is valid RD_LATENCY cycles after the cycle in which rea is high.
- CNT_W, 2, width of the latency counter; must satisfy 2^CNT_W > RD_LATENCY.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ex_en  input  1  request valid from EX.
- ex_mem_op  input  `MEMOPBUS  memory op (`MEMOPLW/LH/LHU/LB/LBU are loads; stores and `MEMOPNOP are non-loads).
- ex_out  input  `WORDDATABUS  EX result: the byte address for loads, the pass-through value otherwise.
- flush  input  1  pipeline flush; discards any in-flight request.
- req_ready  output  1  combinational; request is accepted when ex_en && req_ready.
- addr  output  `WORDADDRBUS  BRAM address, combinational = ex_out.
- rea  output  1  BRAM read enable, combinational; high only in the accept cycle of an aligned load.
- rd_data  input  `WORDDATABUS  BRAM read data.
- out  output  `WORDDATABUS  registered result.
- out_valid  output  1  registered; one-cycle pulse per completed request.
- miss_align  output  1  registered; valid with out_valid.
- busy  output  1  combinational = !req_ready; stall to the upstream pipeline.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, cnt=0.
  - out=0, out_valid=0, miss_align=0; latched op and offset cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=1.
- Accept in IDLE or RESP (ex_en && !flush):
  - Aligned load:
    - rea=1 in the accept cycle.
    - Latch op and ex_out[1:0]; cnt=RD_LATENCY-1.
    - Go to WAIT, or capture directly when RD_LATENCY=1 (cnt reaches 0).
  - Misaligned load (LW with ex_out[1:0]!=0; LH/LHU with ex_out[0]=1):
    - rea=0.
    - Next cycle: out=0, out_valid=1, miss_align=1; state RESP.
  - Non-load op:
    - Next cycle: out=ex_out, out_valid=1, miss_align=0; state RESP.
- WAIT:
  - Decrement cnt each cycle.
  - In the cycle rd_data is valid (RD_LATENCY cycles after accept), register the extracted result at the rising edge.
  - out_valid=1 in the following cycle; state RESP.
  - Load latency from accept cycle T to out_valid is cycle T+RD_LATENCY+1.
- Extraction (little-endian, matching the store byte-lane shift):
  - LW: rd_data.
  - LH/LHU: half = rd_data[16*a1+15 : 16*a1], a1 = latched offset[1]. LH sign-extends bit 15; LHU zero-extends.
  - LB/LBU: byte = rd_data[8*k+7 : 8*k], k = latched offset[1:0]. LB sign-extends bit 7; LBU zero-extends.
- RESP:
  - out_valid is high for exactly this cycle.
  - A new request may be accepted in the same cycle (back-to-back); otherwise go to IDLE.
  - out holds its value until the next capture; out_valid and miss_align clear.
- ex_en low in IDLE/RESP: no state change except RESP→IDLE. rea=0.
- flush:
  - Highest priority. From any state go to IDLE next cycle; no out_valid for the dropped request; blocks accept in its cycle.
  - A BRAM read already issued is harmless and ignored.
- Reset mid-WAIT: immediate return to IDLE, outputs cleared, no stray out_valid after release.
- ex_en while in WAIT: ignored (req_ready=0); upstream holds the request under busy.

Test Plan:
- Reset: assert reset mid-WAIT → out=0, out_valid=0, state IDLE immediately. After release, no out_valid until a new request is accepted.
- LB, ex_out=0x103, rd_data=0x80FF_1234, RD_LATENCY=1:
  - rea=1 at T; out_valid at T+2 with out=0xFFFF_FF80.
  - Repeated with LBU → out=0x0000_0080.
- LH, ex_out=0x202, rd_data=0x9ABC_5678 → out=0xFFFF_9ABC. LHU → 0x0000_9ABC. LW at 0x200 → 0x9ABC_5678.
- Misaligned LW at 0x201 and LH at 0x203 → rea never asserted; next cycle out_valid=1, miss_align=1, out=0.
- Back-to-back: LW accepted, then LB accepted in the RESP cycle, then non-load with ex_out=0x1234_5678.
  - Three out_valid pulses, with no gap between requests beyond the load latency.
  - Last out=0x1234_5678; busy high only during WAIT.
- RD_LATENCY=3: rd_data changes each cycle and is valid only at T+3 → out reflects the T+3 data at T+4. A flush at T+2 → no out_valid, IDLE at T+3.
